// File: rtl/pp_issue_16.sv
// Partial-product issue stage: latches two lanes of 2*CHUNK_W-bit operands and
// streams the four CHUNK_W x CHUNK_W partial products per lane to the accumulator.
module pp_issue_16 #(
  parameter int CHUNK_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2*CHUNK_W-1:0]   a1,
  input  logic [2*CHUNK_W-1:0]   b1,
  input  logic [2*CHUNK_W-1:0]   a2,
  input  logic [2*CHUNK_W-1:0]   b2,
  output logic                   start,
  output logic                   pp_valid,
  input  logic                   out_ready,
  output logic [2*CHUNK_W-1:0]   mult_out1,
  output logic [2*CHUNK_W-1:0]   mult_out2,
  output logic [1:0]             pp_idx,
  output logic                   pp_last,
  output logic                   dbg_state
);

  localparam int OP_W = 2 * CHUNK_W;

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high. Upstream holds in_valid and operands until in_ready; on the
  // output side a beat is consumed on pp_valid && out_ready and every output
  // holds steady until then.

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } state_t;

  state_t           state;
  logic [OP_W-1:0]  a1_q;
  logic [OP_W-1:0]  b1_q;
  logic [OP_W-1:0]  a2_q;
  logic [OP_W-1:0]  b2_q;
  logic [1:0]       next_idx;

  assign dbg_state = state;
  assign next_idx  = pp_idx + 2'd1;

  // idx[1] selects the multiplicand half, idx[0] the multiplier half, giving
  // the order LL, LH, HL, HH.
  function automatic logic [OP_W-1:0] part_prod(
    input logic [OP_W-1:0] a,
    input logic [OP_W-1:0] b,
    input logic [1:0]      idx
  );
    logic [CHUNK_W-1:0] ac;
    logic [CHUNK_W-1:0] bc;
    ac = idx[1] ? a[OP_W-1:CHUNK_W] : a[CHUNK_W-1:0];
    bc = idx[0] ? b[OP_W-1:CHUNK_W] : b[CHUNK_W-1:0];
    return {{CHUNK_W{1'b0}}, ac} * {{CHUNK_W{1'b0}}, bc};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      start     <= 1'b0;
      pp_valid  <= 1'b0;
      pp_last   <= 1'b0;
      pp_idx    <= 2'd0;
      mult_out1 <= '0;
      mult_out2 <= '0;
      a1_q      <= '0;
      b1_q      <= '0;
      a2_q      <= '0;
      b2_q      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a1_q     <= a1;
            b1_q     <= b1;
            a2_q     <= a2;
            b2_q     <= b2;
            in_ready <= 1'b0;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!pp_valid) begin
            // First cycle after accept: products come from the latched copy.
            start     <= 1'b1;
            pp_valid  <= 1'b1;
            pp_idx    <= 2'd0;
            pp_last   <= 1'b0;
            mult_out1 <= part_prod(a1_q, b1_q, 2'd0);
            mult_out2 <= part_prod(a2_q, b2_q, 2'd0);
          end else if (out_ready) begin
            if (pp_idx == 2'd3) begin
              start    <= 1'b0;
              pp_valid <= 1'b0;
              pp_last  <= 1'b0;
              in_ready <= 1'b1;
              state    <= S_IDLE;
            end else begin
              pp_idx    <= next_idx;
              pp_last   <= (next_idx == 2'd3);
              mult_out1 <= part_prod(a1_q, b1_q, next_idx);
              mult_out2 <= part_prod(a2_q, b2_q, next_idx);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  a_ready_excl: assert property (@(posedge clk) disable iff (rst)
    pp_valid |-> !in_ready);

  a_start_tracks_valid: assert property (@(posedge clk) disable iff (rst)
    start == pp_valid);

  a_last_at_idx3: assert property (@(posedge clk) disable iff (rst)
    pp_valid |-> (pp_last == (pp_idx == 2'd3)));

  a_stall_hold: assert property (@(posedge clk) disable iff (rst)
    (pp_valid && !out_ready) |=> (pp_valid && $stable(mult_out1) &&
      $stable(mult_out2) && $stable(pp_idx) && $stable(pp_last)));

endmodule

// File: tb/tb_pp_issue_16.sv
// Bench for pp_issue_16: directed scenarios plus random operations, checked by
// a chunk-arithmetic reference model and a shift-and-add accumulator.
module tb_pp_issue_16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a1, b1, a2, b2;
  logic        start;
  logic        pp_valid;
  logic        out_ready;
  logic [15:0] mult_out1, mult_out2;
  logic [1:0]  pp_idx;
  logic        pp_last;
  logic        dbg_state;

  pp_issue_16 #(.CHUNK_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a1(a1), .b1(b1), .a2(a2), .b2(b2),
    .start(start), .pp_valid(pp_valid), .out_ready(out_ready),
    .mult_out1(mult_out1), .mult_out2(mult_out2),
    .pp_idx(pp_idx), .pp_last(pp_last), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // {start, last, idx[1:0], m1[15:0], m2[15:0]}
  logic [35:0] exp_q[$];
  logic [31:0] prod1_q[$];
  logic [31:0] prod2_q[$];
  logic [31:0] acc1 = 0;
  logic [31:0] acc2 = 0;
  bit          rand_ready = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: split each operand into bytes and multiply with plain integers.
  function automatic logic [15:0] chunk_mul(input logic [15:0] a, input logic [15:0] b, input int k);
    int al, ah, bl, bh, r;
    al = int'(a) % 256;
    ah = int'(a) / 256;
    bl = int'(b) % 256;
    bh = int'(b) / 256;
    case (k)
      0:       r = al * bl;
      1:       r = al * bh;
      2:       r = ah * bl;
      default: r = ah * bh;
    endcase
    return 16'(r);
  endfunction

  task automatic push_model(input logic [15:0] x1, y1, x2, y2);
    for (int k = 0; k < 4; k++)
      exp_q.push_back({1'b1, (k == 3), 2'(k), chunk_mul(x1, y1, k), chunk_mul(x2, y2, k)});
    prod1_q.push_back(32'(x1) * 32'(y1));
    prod2_q.push_back(32'(x2) * 32'(y2));
  endtask

  task automatic flush_model();
    exp_q.delete();
    prod1_q.delete();
    prod2_q.delete();
    acc1 = 0;
    acc2 = 0;
  endtask

  // Driver: present operands until accepted; returns edges waited incl. the accept edge.
  task automatic send_op(input logic [15:0] x1, y1, x2, y2, output int waited);
    logic was_ready;
    in_valid = 1'b1;
    a1 = x1; b1 = y1; a2 = x2; b2 = y2;
    waited = 0;
    forever begin
      if (waited >= 40) begin
        check("accept_timeout", 64'(waited), 64'(0));
        in_valid = 1'b0;
        return;
      end
      was_ready = in_ready;
      @(posedge clk);
      #1;
      waited++;
      if (was_ready) break;
    end
    push_model(x1, y1, x2, y2);
    in_valid = 1'b0;
    a1 = 16'($urandom); b1 = 16'($urandom);
    a2 = 16'($urandom); b2 = 16'($urandom);
  endtask

  // Drive out_ready until the block is idle again; optional stall at one beat index.
  task automatic run_to_idle(input int stall_idx, input int stall_n, output int cyc);
    int stalls;
    cyc = 0;
    stalls = 0;
    forever begin
      if (cyc >= 60) begin
        check("idle_timeout", 64'(cyc), 64'(0));
        break;
      end
      if (rand_ready)
        out_ready = ($urandom_range(0, 3) != 0);
      else if (pp_valid && int'(pp_idx) == stall_idx && stalls < stall_n) begin
        out_ready = 1'b0;
        stalls++;
        check("stall_start", 64'(start), 64'(1));
      end else
        out_ready = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
      if (in_ready) break;
    end
    out_ready = 1'b1;
  endtask

  // Scoreboard: compare consumed beats, stall holds, and reconstructed products.
  logic        prev_stall = 1'b0;
  logic [35:0] prev_obs;
  always @(negedge clk) begin
    logic [35:0] e;
    int sh;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 64'(pp_valid), 64'(1));
        check("hold_beat", {28'd0, start, pp_last, pp_idx, mult_out1, mult_out2}, {28'd0, prev_obs});
      end
      if (pp_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'(pp_idx), 64'(4));
        end else begin
          e = exp_q.pop_front();
          check("beat_start", 64'(start), 64'(e[35]));
          check("beat_last", 64'(pp_last), 64'(e[34]));
          check("beat_idx", 64'(pp_idx), 64'(e[33:32]));
          check("beat_m1", 64'(mult_out1), 64'(e[31:16]));
          check("beat_m2", 64'(mult_out2), 64'(e[15:0]));
          sh = (int'(e[32]) + int'(e[33])) * 8;
          acc1 = acc1 + (32'(mult_out1) << sh);
          acc2 = acc2 + (32'(mult_out2) << sh);
          if (e[34] && prod1_q.size() > 0) begin
            check("acc_lane1", 64'(acc1), 64'(prod1_q.pop_front()));
            check("acc_lane2", 64'(acc2), 64'(prod2_q.pop_front()));
            acc1 = 0;
            acc2 = 0;
          end
        end
      end
      prev_stall = pp_valid && !out_ready;
      prev_obs   = {start, pp_last, pp_idx, mult_out1, mult_out2};
    end
  end

  initial begin
    int w, cyc, guard;
    logic [15:0] x1, y1, x2, y2;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a1 = '0; b1 = '0; a2 = '0; b2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_start", 64'(start), 64'(0));
    check("rst_pp_valid", 64'(pp_valid), 64'(0));
    check("rst_pp_last", 64'(pp_last), 64'(0));
    check("rst_pp_idx", 64'(pp_idx), 64'(0));
    check("rst_mult_outs", {32'd0, mult_out1, mult_out2}, 64'(0));
    rst = 1'b0;

    // Basic stream
    send_op(16'h5678, 16'h1234, 16'hFFFF, 16'hFFFF, w);
    check("t1_accept_wait", 64'(w), 64'(1));
    check("t1_gap_valid", 64'(pp_valid), 64'(0));
    run_to_idle(-1, 0, cyc);
    check("t1_latency", 64'(cyc), 64'(5));
    check("t1_idle_idx_held", 64'(pp_idx), 64'(3));
    check("t1_idle_m1_held", 64'(mult_out1), 64'(16'h060C));

    // Stall at beat 1
    send_op(16'h5678, 16'h1234, 16'hFFFF, 16'hFFFF, w);
    run_to_idle(1, 3, cyc);
    check("t2_latency", 64'(cyc), 64'(8));

    // Busy drop: second op waits until the first IDLE cycle
    send_op(16'h5678, 16'h1234, 16'hFFFF, 16'hFFFF, w);
    send_op(16'h0001, 16'h0001, 16'h00FF, 16'h0101, w);
    check("t3_accept_wait", 64'(w), 64'(6));
    run_to_idle(-1, 0, cyc);
    check("t3_latency", 64'(cyc), 64'(5));

    // Zero / edge operands
    send_op(16'h0000, 16'hABCD, 16'hFF00, 16'h00FF, w);
    run_to_idle(-1, 0, cyc);
    send_op(16'h00FF, 16'hFF00, 16'h8000, 16'h0001, w);
    run_to_idle(-1, 0, cyc);

    // Reset mid-operation at beat 2
    send_op(16'hBEEF, 16'hCAFE, 16'h1357, 16'h2468, w);
    guard = 0;
    while (!(pp_valid && pp_idx == 2'd2) && guard < 20) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("t5_reach_idx2", 64'(pp_idx), 64'(2));
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t5_start", 64'(start), 64'(0));
    check("t5_pp_valid", 64'(pp_valid), 64'(0));
    check("t5_in_ready", 64'(in_ready), 64'(1));
    check("t5_pp_idx", 64'(pp_idx), 64'(0));
    check("t5_pp_last", 64'(pp_last), 64'(0));
    check("t5_mult_outs", {32'd0, mult_out1, mult_out2}, 64'(0));
    rst = 1'b0;
    flush_model();
    send_op(16'h1234, 16'h5678, 16'h0F0F, 16'hF0F0, w);
    run_to_idle(-1, 0, cyc);
    check("t5_fresh_latency", 64'(cyc), 64'(5));

    // Random operations with random backpressure
    rand_ready = 1'b1;
    for (int n = 0; n < 100; n++) begin
      x1 = 16'($urandom); y1 = 16'($urandom);
      x2 = 16'($urandom); y2 = 16'($urandom);
      case ($urandom_range(0, 7))
        0: x1 = 16'hFFFF;
        1: y2 = 16'h0000;
        2: begin x2 = 16'h00FF; y1 = 16'hFF00; end
        default: ;
      endcase
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send_op(x1, y1, x2, y2, w);
      run_to_idle(-1, 0, cyc);
    end
    rand_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("model_drained", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
